// File: rtl/chunk_arb_pkg.sv
// Shared types and constants for the stereo chunk write arbiter.
package chunk_arb_pkg;

  localparam int CHUNK_W = 128;
  localparam int STAT_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/chunk_addr_gen.sv
// Per-requester frame-buffer address counter: wraps at the frame size,
// resynchronises to zero on tlast, and adds the requester's base address.
module chunk_addr_gen #(
  parameter int unsigned FRAME_CHUNKS = 4800,
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              last,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned CNT_W = (FRAME_CHUNKS > 1) ? $clog2(FRAME_CHUNKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FRAME_CHUNKS - 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  logic [CNT_W-1:0] cnt;

  // tlast wins over the wrap so a short frame still realigns the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      if (last || cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Sum is taken modulo 2^ADDR_W
  assign addr = BASE + ADDR_W'(cnt);

endmodule

// File: rtl/chunk_write_arbiter.sv
// Round-robin burst arbiter merging two chunk streams onto one registered write port.
// Optional statistics counters are built when CHUNK_ARB_STATS_EN is defined.
//
// Handshake: a beat moves on any rising edge where valid && ready are both high;
// valid never depends on ready, and a raised valid holds its payload until taken.
module chunk_write_arbiter
  import chunk_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned FRAME_CHUNKS = 4800,
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned BASE_ADDR_0  = 0,
  parameter int unsigned BASE_ADDR_1  = 4800
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               s0_tvalid,
  output logic               s0_tready,
  input  logic [CHUNK_W-1:0] s0_tdata,
  input  logic               s0_tlast,
  input  logic               s1_tvalid,
  output logic               s1_tready,
  input  logic [CHUNK_W-1:0] s1_tdata,
  input  logic               s1_tlast,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [CHUNK_W-1:0] m_tdata,
  output logic [ADDR_W-1:0]  m_taddr,
  output logic               m_tid,
  output logic               m_tlast,
  output logic [1:0]         grant_out
`ifdef CHUNK_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_chunks_0,
  output logic [STAT_W-1:0]  stat_chunks_1,
  output logic [STAT_W-1:0]  stat_stall
`endif
);

  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  arb_state_t        state;
  arb_state_t        state_next;
  req_id_t           last_served;
  logic [7:0]        burst_cnt;
  logic              out_free;
  logic              burst_end;
  logic              acc0;
  logic              acc1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;

  assign out_free  = !m_tvalid || m_tready;
  assign burst_end = (burst_cnt == BURST_LAST);
  assign acc0      = s0_tvalid && s0_tready;
  assign acc1      = s1_tvalid && s1_tready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A grant ends on a full burst, a frame end, or a requester going quiet
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          state_next = (last_served == 1'b1) ? GRANT0 : GRANT1;
        end else if (s0_tvalid) begin
          state_next = GRANT0;
        end else if (s1_tvalid) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (!s0_tvalid || (acc0 && (burst_end || s0_tlast))) begin
          state_next = IDLE;
        end
      end
      GRANT1: begin
        if (!s1_tvalid || (acc1 && (burst_end || s1_tlast))) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    grant_out = 2'b00;
    case (state)
      GRANT0: begin
        s0_tready = out_free;
        grant_out = 2'b01;
      end
      GRANT1: begin
        s1_tready = out_free;
        grant_out = 2'b10;
      end
      default: ;
    endcase
  end

  // Burst length and fairness pointer bookkeeping
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      burst_cnt   <= '0;
      last_served <= 1'b1;
    end else begin
      if (state == IDLE) begin
        burst_cnt <= '0;
      end else if (acc0 || acc1) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (state == GRANT0 && state_next == IDLE) begin
        last_served <= 1'b0;
      end else if (state == GRANT1 && state_next == IDLE) begin
        last_served <= 1'b1;
      end
    end
  end

  chunk_addr_gen #(
    .FRAME_CHUNKS(FRAME_CHUNKS),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR_0)
  ) u_addr0 (
    .clk  (clk_in),
    .rst_n(rst_n_in),
    .inc  (acc0),
    .last (s0_tlast),
    .addr (addr0)
  );

  chunk_addr_gen #(
    .FRAME_CHUNKS(FRAME_CHUNKS),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR_1)
  ) u_addr1 (
    .clk  (clk_in),
    .rst_n(rst_n_in),
    .inc  (acc1),
    .last (s1_tlast),
    .addr (addr1)
  );

  // Output register: reload on accept, otherwise empty once drained
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_taddr  <= '0;
      m_tid    <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (acc0) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s0_tdata;
      m_taddr  <= addr0;
      m_tid    <= 1'b0;
      m_tlast  <= s0_tlast;
    end else if (acc1) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s1_tdata;
      m_taddr  <= addr1;
      m_tid    <= 1'b1;
      m_tlast  <= s1_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

`ifdef CHUNK_ARB_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_chunks_0 <= '0;
      stat_chunks_1 <= '0;
      stat_stall    <= '0;
    end else begin
      if (m_tvalid && m_tready && !m_tid && stat_chunks_0 != '1) begin
        stat_chunks_0 <= stat_chunks_0 + 1'b1;
      end
      if (m_tvalid && m_tready && m_tid && stat_chunks_1 != '1) begin
        stat_chunks_1 <= stat_chunks_1 + 1'b1;
      end
      if (m_tvalid && !m_tready && stat_stall != '1) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_chunk_write_arbiter.sv
// Directed bench for chunk_write_arbiter: burst sizing, round-robin order,
// address wrap/resync, output stall and asynchronous reset.
module tb_chunk_write_arbiter;
  import chunk_arb_pkg::*;

  localparam int ADDR_W = 27;
  localparam int W      = 2 + ADDR_W + CHUNK_W;

  logic               clk_in = 1'b0;
  logic               rst_n_in = 1'b0;
  logic               s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic               s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic [CHUNK_W-1:0] s0_tdata = '0, s1_tdata = '0;
  logic               m_tready = 1'b0;
  logic               s0_tready, s1_tready;
  logic               m_tvalid, m_tid, m_tlast;
  logic [CHUNK_W-1:0] m_tdata;
  logic [ADDR_W-1:0]  m_taddr;
  logic [1:0]         grant_out;
  logic               w_s0_tready, w_s1_tready, w_m_tvalid, w_m_tid, w_m_tlast;
  logic [CHUNK_W-1:0] w_m_tdata;
  logic [ADDR_W-1:0]  w_m_taddr;
  logic [1:0]         w_grant_out;
`ifdef CHUNK_ARB_STATS_EN
  logic [31:0] stat_chunks_0, stat_chunks_1, stat_stall;
  logic [31:0] w_stat_chunks_0, w_stat_chunks_1, w_stat_stall;
`endif

  always #5 clk_in = ~clk_in;

  chunk_write_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_taddr(m_taddr),
    .m_tid(m_tid), .m_tlast(m_tlast), .grant_out(grant_out)
`ifdef CHUNK_ARB_STATS_EN
    , .stat_chunks_0(stat_chunks_0), .stat_chunks_1(stat_chunks_1), .stat_stall(stat_stall)
`endif
  );

  // Same stimulus, four-chunk frames, to observe counter wrap
  chunk_write_arbiter #(.FRAME_CHUNKS(4)) dut_w (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .s0_tvalid(s0_tvalid), .s0_tready(w_s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(w_s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
    .m_tvalid(w_m_tvalid), .m_tready(m_tready), .m_tdata(w_m_tdata), .m_taddr(w_m_taddr),
    .m_tid(w_m_tid), .m_tlast(w_m_tlast), .grant_out(w_grant_out)
`ifdef CHUNK_ARB_STATS_EN
    , .stat_chunks_0(w_stat_chunks_0), .stat_chunks_1(w_stat_chunks_1), .stat_stall(w_stat_stall)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [CHUNK_W:0]   src0_q[$];
  logic [CHUNK_W:0]   src1_q[$];
  logic [W-1:0]       exp_q[$];
  logic [W-1:0]       out_q[$];
  int                 acc_cyc[$];
  logic [ADDR_W-1:0]  w_addr_q[$];
  logic               snap_s0_tready, snap_m_tvalid;
  logic [CHUNK_W-1:0] snap_tdata;
  logic [ADDR_W-1:0]  snap_taddr;

  function automatic logic [CHUNK_W-1:0] dat(input int s, input int i);
    return {32'(s + 1), 64'h0123_4567_89ab_cdef, 32'(i)};
  endfunction

  function automatic logic [W-1:0] pack(input logic last, input logic tid,
                                        input int addr, input logic [CHUNK_W-1:0] d);
    return {last, tid, ADDR_W'(addr), d};
  endfunction

  task automatic drive_srcs();
    s0_tvalid = (src0_q.size() != 0);
    {s0_tlast, s0_tdata} = s0_tvalid ? src0_q[0] : '0;
    s1_tvalid = (src1_q.size() != 0);
    {s1_tlast, s1_tdata} = s1_tvalid ? src1_q[0] : '0;
  endtask

  // One clock: observe on the falling edge, update sources after the rising edge
  task automatic step();
    logic a0, a1;
    @(negedge clk_in);
    cyc++;
    a0 = s0_tvalid && s0_tready;
    a1 = s1_tvalid && s1_tready;
    if (a0 || a1) acc_cyc.push_back(cyc);
    if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tid, m_taddr, m_tdata});
    if (w_m_tvalid && m_tready) w_addr_q.push_back(w_m_taddr);
    snap_s0_tready = s0_tready;
    snap_m_tvalid  = m_tvalid;
    snap_tdata     = m_tdata;
    snap_taddr     = m_taddr;
    @(posedge clk_in);
    #1;
    if (a0) void'(src0_q.pop_front());
    if (a1) void'(src1_q.pop_front());
    drive_srcs();
  endtask

  task automatic run_until(input int n);
    int budget = 0;
    while (out_q.size() < n && budget < 400) begin
      step();
      budget++;
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    m_tready = 1'b1;
    src0_q.delete(); src1_q.delete();
    exp_q.delete(); out_q.delete(); acc_cyc.delete(); w_addr_q.delete();
    drive_srcs();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({m_tvalid, m_tid, m_tlast} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got=%b exp=000", {m_tvalid, m_tid, m_tlast});
    end
    total++;
    if (m_tdata !== '0 || m_taddr !== '0) begin
      bad++; $display("FAIL reset_data: got data=%h addr=%0d exp=0", m_tdata, m_taddr);
    end
    total++;
    if ({grant_out, s0_tready, s1_tready} !== 4'b0000) begin
      bad++; $display("FAIL reset_grant: got=%b exp=0000", {grant_out, s0_tready, s1_tready});
    end
`ifdef CHUNK_ARB_STATS_EN
    total++;
    if (stat_chunks_0 !== 0 || stat_chunks_1 !== 0 || stat_stall !== 0) begin
      bad++; $display("FAIL reset_stats: got=%0d/%0d/%0d exp=0", stat_chunks_0, stat_chunks_1, stat_stall);
    end
`endif
  endtask

  task automatic test_single_stream();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      src0_q.push_back({1'b0, dat(0, i)});
      exp_q.push_back(pack(1'b0, 1'b0, i, dat(0, i)));
    end
    drive_srcs();
    run_until(20);
    total++;
    if (out_q.size() != 20) begin
      bad++; $display("FAIL single_count: got=%0d exp=20", out_q.size());
    end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (out_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL single_out[%0d]: got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    // Bursts of 8, 8, 4: one idle cycle before the 9th and 17th accepts
    for (int i = 1; i < 20; i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] != ((i == 8 || i == 16) ? 2 : 1)) begin
        bad++; $display("FAIL single_gap[%0d]: got=%0d exp=%0d", i,
                        acc_cyc[i] - acc_cyc[i-1], (i == 8 || i == 16) ? 2 : 1);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      src0_q.push_back({1'b0, dat(0, i)});
      src1_q.push_back({1'b0, dat(1, i)});
    end
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = (b / 2) * 8 + j;
        if (b % 2 == 0) exp_q.push_back(pack(1'b0, 1'b0, idx, dat(0, idx)));
        else            exp_q.push_back(pack(1'b0, 1'b1, 4800 + idx, dat(1, idx)));
      end
    end
    drive_srcs();
    run_until(48);
    total++;
    if (out_q.size() != 48) begin
      bad++; $display("FAIL rr_count: got=%0d exp=48", out_q.size());
    end
    for (int i = 0; i < 48; i++) begin
      total++;
      if (out_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rr_out[%0d]: got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    for (int b = 1; b < 6; b++) begin
      total++;
      if (acc_cyc[b*8] - acc_cyc[b*8-1] != 2) begin
        bad++; $display("FAIL rr_gap[%0d]: got=%0d exp=2", b, acc_cyc[b*8] - acc_cyc[b*8-1]);
      end
    end
  endtask

  task automatic test_tlast_resync();
    do_reset();
    for (int i = 0; i < 5; i++) src1_q.push_back({i == 2, dat(1, i)});
    exp_q.push_back(pack(1'b0, 1'b1, 4800, dat(1, 0)));
    exp_q.push_back(pack(1'b0, 1'b1, 4801, dat(1, 1)));
    exp_q.push_back(pack(1'b1, 1'b1, 4802, dat(1, 2)));
    exp_q.push_back(pack(1'b0, 1'b1, 4800, dat(1, 3)));
    exp_q.push_back(pack(1'b0, 1'b1, 4801, dat(1, 4)));
    drive_srcs();
    run_until(5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL tlast_out[%0d]: got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    total++;
    if (acc_cyc[3] - acc_cyc[2] != 2) begin
      bad++; $display("FAIL tlast_release: got gap=%0d exp=2", acc_cyc[3] - acc_cyc[2]);
    end
  endtask

  task automatic test_frame_wrap();
    int wrap_exp[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) src0_q.push_back({1'b0, dat(0, i)});
    drive_srcs();
    run_until(6);
    total++;
    if (w_addr_q.size() != 6) begin
      bad++; $display("FAIL wrap_count: got=%0d exp=6", w_addr_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (w_addr_q[i] !== ADDR_W'(wrap_exp[i])) begin
        bad++; $display("FAIL wrap_addr[%0d]: got=%0d exp=%0d", i, w_addr_q[i], wrap_exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      src0_q.push_back({1'b0, dat(0, i)});
      exp_q.push_back(pack(1'b0, 1'b0, i, dat(0, i)));
    end
    drive_srcs();
    run_until(3);
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (snap_tdata !== dat(0, 3) || snap_taddr !== ADDR_W'(3)) begin
        bad++; $display("FAIL stall_hold[%0d]: got addr=%0d data=%h exp addr=3 data=%h",
                        k, snap_taddr, snap_tdata, dat(0, 3));
      end
      total++;
      if (snap_s0_tready !== 1'b0 || snap_m_tvalid !== 1'b1) begin
        bad++; $display("FAIL stall_ready[%0d]: got tready=%b tvalid=%b exp 0/1",
                        k, snap_s0_tready, snap_m_tvalid);
      end
    end
    m_tready = 1'b1;
    run_until(12);
    step();
    total++;
    if (out_q.size() != 12) begin
      bad++; $display("FAIL stall_count: got=%0d exp=12", out_q.size());
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (out_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_out[%0d]: got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
`ifdef CHUNK_ARB_STATS_EN
    total++;
    if (stat_stall !== 32'd5 || stat_chunks_0 !== 32'd12 || stat_chunks_1 !== 32'd0) begin
      bad++; $display("FAIL stall_stats: got stall=%0d c0=%0d c1=%0d exp 5/12/0",
                      stat_stall, stat_chunks_0, stat_chunks_1);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [CHUNK_W-1:0] front;
    do_reset();
    for (int i = 0; i < 10; i++) src0_q.push_back({1'b0, dat(0, 100 + i)});
    drive_srcs();
    run_until(3);
    #2;
    rst_n_in = 1'b0;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || m_taddr !== '0 || m_tdata !== '0) begin
      bad++; $display("FAIL areset_out: got tvalid=%b addr=%0d data=%h exp 0", m_tvalid, m_taddr, m_tdata);
    end
    total++;
    if (grant_out !== 2'b00 || s0_tready !== 1'b0) begin
      bad++; $display("FAIL areset_grant: got grant=%b tready=%b exp 00/0", grant_out, s0_tready);
    end
    front = src0_q[0][CHUNK_W-1:0];
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    out_q.delete();
    run_until(1);
    total++;
    if (out_q[0] !== pack(1'b0, 1'b0, 0, front)) begin
      bad++; $display("FAIL areset_next: got=%h exp=%h", out_q[0], pack(1'b0, 1'b0, 0, front));
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_tlast_resync();
    test_frame_wrap();
    test_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunk_write_arbiter.md
# chunk_write_arbiter

Two-requester scheduler sharing one 128-bit memory write port between two `stacker` chunk streams, one per camera of the stereo pair. Grants the port in bounded bursts, round-robin. Generates per-stream frame-buffer addresses in 128-bit word units. Presents a registered AXI-Stream-style write stream to the MIG write adapter.

## Interface
- `BURST_LEN`, 8: maximum chunks per grant; legal range 1..255.
- `FRAME_CHUNKS`, 4800: chunks per frame (320x240 px / 16).
- `ADDR_W`, 27: address width in 128-bit words.
- `BASE_ADDR_0`, 0: frame-buffer base for requester 0.
- `BASE_ADDR_1`, 4800: frame-buffer base for requester 1.
- `clk_in` in 1: sole clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `s0_tvalid` / `s1_tvalid` in 1: chunk valid from stacker 0 / 1.
- `s0_tready` / `s1_tready` out 1: chunk ready to stacker 0 / 1.
- `s0_tdata` / `s1_tdata` in 128: chunk payload.
- `s0_tlast` / `s1_tlast` in 1: last chunk of frame.
- `m_tvalid` out 1: write command valid.
- `m_tready` in 1: write command ready.
- `m_tdata` out 128: write payload.
- `m_taddr` out ADDR_W: word address.
- `m_tid` out 1: source requester.
- `m_tlast` out 1: frame end, forwarded.
- `grant_out` out 2: one-hot current grant; debug only.
- `stat_chunks_0` / `stat_chunks_1` out 32: chunks forwarded per requester; present only with the macro.
- `stat_stall` out 32: stall-cycle count; present only with the macro.

## Operation
- FSM states: `IDLE`, `GRANT0`, `GRANT1`.
- `IDLE`:
  - Exactly one `sN_tvalid` high: go to `GRANTN`.
  - Both high: go to the requester not served last. The last-served pointer resets to 1, so requester 0 wins the first tie.
  - Neither high: stay in `IDLE`.
- `GRANTN`:
  - `sN_tready = !m_tvalid || m_tready`. The other requester's tready is 0.
  - An accept loads the output register: data, tlast, tid = N, addr = `BASE_ADDR_N + cntN`.
  - The address sum is computed in ADDR_W bits and truncated.
- Release from `GRANTN` to `IDLE` on any of the following; the pointer is then set to N:
  - accept with burst count == `BURST_LEN-1`;
  - accept with `sN_tlast`;
  - a cycle with `sN_tvalid` low.
- `IDLE` costs one cycle per grant. Back-to-back grants therefore leave one idle cycle between bursts.
- Address counter `cntN` (0..`FRAME_CHUNKS-1`), on each accept from N:
  - normal case: +1;
  - wraps to 0 after `FRAME_CHUNKS-1`;
  - forced to 0 when the accepted chunk carries tlast (frame resync). Tlast takes precedence over wrap.
- Burst count clears on entry to `GRANTN`.

## Timing
- Reset values: all outputs 0, `cnt0 = cnt1 = 0`, state `IDLE`. Stat counters are 0 when present.
- Latency: accept on cycle t gives `m_tvalid` on t+1 with the matching address.
- Throughput: one chunk per cycle within a burst.
- The output register holds its value while `m_tvalid && !m_tready`. No input is accepted while it is full and stalled.
- Accept and output drain in the same cycle: the register reloads and `m_tvalid` stays 1.
- `m_tvalid` falls only after a drain with no simultaneous accept.
- Asynchronous reset mid-burst drops the held chunk and clears all counters. The stackers resynchronise at the next frame.

## Configuration
- `CHUNK_ARB_STATS_EN` defined:
  - `stat_chunks_N` increments on every output transfer (`m_tvalid && m_tready`) tagged `m_tid = N`;
  - `stat_stall` increments on every cycle with `m_tvalid && !m_tready`;
  - all three saturate at 2^32-1.
- Not defined: the stat ports and counters are absent.

## Structure
- Package `chunk_arb_pkg`:
  - `CHUNK_W = 128`;
  - state enum `arb_state_t`;
  - requester id typedef `req_id_t` (1 bit).
- Sub-module `chunk_addr_gen`: per-requester address counter with wrap/tlast reset and base addition. Instantiated twice.

## Test plan
- Only s0 streams 20 chunks, `m_tready = 1`:
  - grants of 8, 8, 4 with one idle cycle between;
  - addresses 0..19, `m_tid = 0`.
- Both streams continuously valid, `m_tready = 1`:
  - bursts alternate 0, 1, 0…, 8 chunks each, requester 0 first;
  - s1 addresses start at 4800.
- s1 sends 3 chunks with tlast on the 3rd, then 2 more:
  - grant released after the 3rd chunk;
  - the next two chunks are addressed 4800 and 4801.
- `FRAME_CHUNKS = 4` override, s0 sends 6 chunks without tlast: addresses 0, 1, 2, 3, 0, 1.
- `m_tready` held low 5 cycles mid-burst:
  - `m_tdata` and `m_taddr` stable throughout;
  - `s0_tready` = 0;
  - `stat_stall = 5` with `CHUNK_ARB_STATS_EN`;
  - no chunk lost or duplicated.
- `rst_n_in` pulsed low mid-burst (asynchronously): outputs go to 0 immediately, and the next s0 chunk is addressed 0.
